// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - shader request/response and framebuffer write bundle

interface frame_sequencer_if #(
   parameter int ROW_BITS     = 8,
   parameter int COL_BITS     = 8,
   parameter int COORD_BITS   = 8,
   parameter int PALETTE_BITS = 8,
   parameter int PIXEL_BITS   = 8
);
   // Current voxel and pixel presented to the shader
   logic [COORD_BITS-1:0]        voxel_x;
   logic [COORD_BITS-1:0]        voxel_y;
   logic [COORD_BITS-1:0]        voxel_z;
   logic [PALETTE_BITS-1:0]      voxel_id;
   logic [ROW_BITS-1:0]          row;
   logic [COL_BITS-1:0]          col;

   // Level requests and their completion strobes
   logic                         do_rasterize;
   logic                         rasterizing_done;
   logic                         do_shade;
   logic                         shading_done;
   logic [PIXEL_BITS-1:0]        pixel;

   // Framebuffer write port
   logic                         fb_we;
   logic [ROW_BITS+COL_BITS-1:0] fb_addr;
   logic [PIXEL_BITS-1:0]        fb_data;

   // Sequencer side
   modport master (
      output voxel_x, voxel_y, voxel_z, voxel_id, row, col,
      output do_rasterize, do_shade,
      input  rasterizing_done, shading_done, pixel,
      output fb_we, fb_addr, fb_data
   );

   // Shader / framebuffer side
   modport slave (
      input  voxel_x, voxel_y, voxel_z, voxel_id, row, col,
      input  do_rasterize, do_shade,
      output rasterizing_done, shading_done, pixel,
      input  fb_we, fb_addr, fb_data
   );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - walks every pixel of a frame through the voxel list and shader

module frame_sequencer #(
   parameter int ROW_BITS        = 8,
   parameter int COL_BITS        = 8,
   parameter int NUM_ROWS        = 120,
   parameter int NUM_COLS        = 160,
   parameter int COORD_BITS      = 8,
   parameter int PALETTE_BITS    = 8,
   parameter int PIXEL_BITS      = 8,
   parameter int VOXEL_ADDR_BITS = 10
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [VOXEL_ADDR_BITS:0]              voxel_count,
   output logic                                  busy,
   output logic                                  frame_done,
   output logic [VOXEL_ADDR_BITS-1:0]            vox_rd_addr,
   input  logic [3*COORD_BITS+PALETTE_BITS-1:0]  vox_rd_data,
   frame_sequencer_if.master                     shd
);

   localparam logic [ROW_BITS-1:0]        LAST_ROW = ROW_BITS'(NUM_ROWS - 1);
   localparam logic [COL_BITS-1:0]        LAST_COL = COL_BITS'(NUM_COLS - 1);
   localparam logic [VOXEL_ADDR_BITS:0]   IDX_ONE  = (VOXEL_ADDR_BITS+1)'(1);
   localparam logic [ROW_BITS-1:0]        ROW_ONE  = ROW_BITS'(1);
   localparam logic [COL_BITS-1:0]        COL_ONE  = COL_BITS'(1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      RAST,
      GAP,
      SHADE,
      WRITE,
      DONE
   } state_t;

   state_t                       state_q;
   state_t                       state_d;

   logic [VOXEL_ADDR_BITS:0]     count_q;
   logic [VOXEL_ADDR_BITS:0]     index_q;
   logic [VOXEL_ADDR_BITS:0]     index_inc;
   logic                         gap_to_shade_q;
   logic [ROW_BITS-1:0]          row_q;
   logic [COL_BITS-1:0]          col_q;
   logic [COORD_BITS-1:0]        vx_q;
   logic [COORD_BITS-1:0]        vy_q;
   logic [COORD_BITS-1:0]        vz_q;
   logic [PALETTE_BITS-1:0]      vid_q;
   logic [PIXEL_BITS-1:0]        fb_data_q;
   logic                         last_pixel;

   assign index_inc  = index_q + IDX_ONE;
   assign last_pixel = (row_q == LAST_ROW) && (col_q == LAST_COL);

   // The read address is simply the voxel index; memory returns data one cycle later (LOAD)
   assign vox_rd_addr  = index_q[VOXEL_ADDR_BITS-1:0];

   assign shd.voxel_x  = vx_q;
   assign shd.voxel_y  = vy_q;
   assign shd.voxel_z  = vz_q;
   assign shd.voxel_id = vid_q;
   assign shd.row      = row_q;
   assign shd.col      = col_q;
   assign shd.fb_addr  = {row_q, col_q};
   assign shd.fb_data  = fb_data_q;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and state-decoded outputs; requests are pure state decodes so they can never overlap
   always_comb begin
      state_d          = state_q;
      busy             = 1'b0;
      frame_done       = 1'b0;
      shd.do_rasterize = 1'b0;
      shd.do_shade     = 1'b0;
      shd.fb_we        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (voxel_count == '0) ? SHADE : FETCH;
            end
         end
         FETCH: begin
            busy    = 1'b1;
            state_d = LOAD;
         end
         LOAD: begin
            busy    = 1'b1;
            state_d = RAST;
         end
         RAST: begin
            busy             = 1'b1;
            shd.do_rasterize = 1'b1;
            if (shd.rasterizing_done) begin
               state_d = GAP;
            end
         end
         GAP: begin
            busy    = 1'b1;
            state_d = gap_to_shade_q ? SHADE : FETCH;
         end
         SHADE: begin
            busy         = 1'b1;
            shd.do_shade = 1'b1;
            if (shd.shading_done) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            busy      = 1'b1;
            shd.fb_we = 1'b1;
            if (last_pixel) begin
               state_d = DONE;
            end else if (count_q == '0) begin
               state_d = SHADE;
            end else begin
               state_d = FETCH;
            end
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Frame datapath: latched count, voxel index, pixel position, voxel and pixel capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q        <= '0;
         index_q        <= '0;
         gap_to_shade_q <= 1'b0;
         row_q          <= '0;
         col_q          <= '0;
         vx_q           <= '0;
         vy_q           <= '0;
         vz_q           <= '0;
         vid_q          <= '0;
         fb_data_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  count_q        <= voxel_count;
                  index_q        <= '0;
                  gap_to_shade_q <= 1'b0;
                  row_q          <= '0;
                  col_q          <= '0;
               end
            end
            LOAD: begin
               vx_q  <= vox_rd_data[COORD_BITS-1:0];
               vy_q  <= vox_rd_data[2*COORD_BITS-1:COORD_BITS];
               vz_q  <= vox_rd_data[3*COORD_BITS-1:2*COORD_BITS];
               vid_q <= vox_rd_data[3*COORD_BITS+PALETTE_BITS-1:3*COORD_BITS];
            end
            RAST: begin
               if (shd.rasterizing_done) begin
                  index_q        <= index_inc;
                  gap_to_shade_q <= (index_inc == count_q);
               end
            end
            SHADE: begin
               if (shd.shading_done) begin
                  fb_data_q <= shd.pixel;
               end
            end
            WRITE: begin
               index_q        <= '0;
               gap_to_shade_q <= 1'b0;
               // Position is frozen on the last pixel; the next start reloads it
               if (!last_pixel) begin
                  if (col_q == LAST_COL) begin
                     col_q <= '0;
                     row_q <= row_q + ROW_ONE;
                  end else begin
                     col_q <= col_q + COL_ONE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer

module tb_frame_sequencer;

   localparam int ROWS = 2;
   localparam int COLS = 3;
   localparam int AW   = 10;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   voxel_count = '0;
   logic          busy;
   logic          frame_done;
   logic [AW-1:0] vox_rd_addr;
   logic [31:0]   vox_rd_data = '0;

   frame_sequencer_if #(.ROW_BITS(8), .COL_BITS(8), .COORD_BITS(8),
                        .PALETTE_BITS(8), .PIXEL_BITS(8)) sif ();

   frame_sequencer #(
      .ROW_BITS(8), .COL_BITS(8), .NUM_ROWS(ROWS), .NUM_COLS(COLS),
      .COORD_BITS(8), .PALETTE_BITS(8), .PIXEL_BITS(8), .VOXEL_ADDR_BITS(AW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .voxel_count (voxel_count),
      .busy        (busy),
      .frame_done  (frame_done),
      .vox_rd_addr (vox_rd_addr),
      .vox_rd_data (vox_rd_data),
      .shd         (sif)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Stub shader configuration
   int rast_delay  = 3;
   int shade_delay = 3;

   // Monitor results
   logic [15:0] wr_addr_q[$];
   logic [7:0]  wr_data_q[$];
   logic [7:0]  rise_x_q[$];
   logic [AW-1:0] rise_a_q[$];
   int fd_cnt = 0;
   int shade_rise = 0;
   int overlap = 0;
   int unstable = 0;
   int run = 0;
   int max_run = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Voxel memory: x=i, y=i+0x40, z=i+0x80, id=i+1; data follows the previous cycle's address
   initial begin
      logic [AW-1:0] prev_addr;
      logic [7:0] i8;
      prev_addr = '0;
      forever begin
         @(negedge clock);
         i8 = prev_addr[7:0];
         vox_rd_data = {i8 + 8'd1, i8 + 8'h80, i8 + 8'h40, i8};
         prev_addr = vox_rd_addr;
      end
   end

   // Stub shader: raises done after the configured number of request cycles
   initial begin
      int rc;
      int sc;
      rc = 0;
      sc = 0;
      sif.rasterizing_done = 1'b0;
      sif.shading_done = 1'b0;
      sif.pixel = '0;
      forever begin
         @(negedge clock);
         if (sif.do_rasterize) begin
            if (rc >= rast_delay) sif.rasterizing_done = 1'b1;
            else rc++;
         end else begin
            sif.rasterizing_done = 1'b0;
            rc = 0;
         end
         if (sif.do_shade) begin
            if (sc >= shade_delay) begin
               sif.shading_done = 1'b1;
               sif.pixel = {sif.row[3:0], sif.col[3:0]};
            end else sc++;
         end else begin
            sif.shading_done = 1'b0;
            sif.pixel = '0;
            sc = 0;
         end
      end
   end

   // Monitor: writes, request rises, overlap, stability and request run length
   initial begin
      logic prev_r;
      logic prev_s;
      logic [47:0] prev_snap;
      logic [47:0] snap;
      prev_r = 1'b0;
      prev_s = 1'b0;
      prev_snap = '0;
      forever begin
         @(negedge clock);
         snap = {sif.row, sif.col, sif.voxel_x, sif.voxel_y, sif.voxel_z, sif.voxel_id};
         if (sif.fb_we) begin
            wr_addr_q.push_back(sif.fb_addr);
            wr_data_q.push_back(sif.fb_data);
         end
         if (frame_done) fd_cnt++;
         if (sif.do_rasterize && !prev_r) begin
            rise_x_q.push_back(sif.voxel_x);
            rise_a_q.push_back(vox_rd_addr);
         end
         if (sif.do_shade && !prev_s) shade_rise++;
         if ((sif.do_rasterize && sif.do_shade) || (prev_r && sif.do_shade) ||
             (prev_s && sif.do_rasterize)) overlap++;
         if (((sif.do_rasterize && prev_r) || (sif.do_shade && prev_s)) && snap != prev_snap)
            unstable++;
         if (sif.do_rasterize) begin
            run++;
            if (run > max_run) max_run = run;
         end else run = 0;
         prev_r = sif.do_rasterize;
         prev_s = sif.do_shade;
         prev_snap = snap;
      end
   end

   task automatic clear_mon();
      wr_addr_q.delete();
      wr_data_q.delete();
      rise_x_q.delete();
      rise_a_q.delete();
      fd_cnt = 0;
      shade_rise = 0;
      max_run = 0;
   endtask

   task automatic start_frame(input int cnt);
      @(negedge clock);
      #1;
      start = 1'b1;
      voxel_count = (AW+1)'(cnt);
      @(negedge clock);
      #1;
      start = 1'b0;
      voxel_count = '0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (fd_cnt == 0 && n < budget) begin
         @(negedge clock);
         #1;
         n++;
      end
      check({tag, "_timeout"}, (fd_cnt == 0) ? 32'd1 : 32'd0, 32'd0);
      repeat (3) @(negedge clock);
      #1;
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_nwrites"}, wr_addr_q.size(), ROWS * COLS);
      check({tag, "_ndone"}, fd_cnt, 1);
      for (int k = 0; k < ROWS * COLS && k < wr_addr_q.size(); k++) begin
         check({tag, "_addr"}, wr_addr_q[k], (k / COLS) * 256 + (k % COLS));
         check({tag, "_data"}, wr_data_q[k], (k / COLS) * 16 + (k % COLS));
      end
   endtask

   task automatic check_rises(input string tag, input int cnt);
      check({tag, "_nrise"}, rise_x_q.size(), ROWS * COLS * cnt);
      for (int k = 0; k < ROWS * COLS * cnt && k < rise_x_q.size(); k++) begin
         check({tag, "_vx"}, rise_x_q[k], k % cnt);
         check({tag, "_vaddr"}, rise_a_q[k], k % cnt);
      end
   endtask

   initial begin
      int n;
      // Reset state
      repeat (2) @(negedge clock);
      #1;
      check("rst_busy", busy, 0);
      check("rst_fd", frame_done, 0);
      check("rst_req", {sif.do_rasterize, sif.do_shade, sif.fb_we}, 0);
      check("rst_pos", {sif.row, sif.col, vox_rd_addr}, 0);
      reset = 1'b1;

      // Reset mid-RAST: second voxel of pixel (0,1)
      start_frame(3);
      check("t1_busy", busy, 1);
      n = 0;
      while (!(wr_addr_q.size() == 1 && rise_x_q.size() == 5 && sif.do_rasterize) && n < 500) begin
         @(negedge clock);
         #1;
         n++;
      end
      check("t1_reach", (n < 500) ? 32'd1 : 32'd0, 32'd1);
      check("t1_pre_vx", sif.voxel_x, 1);
      check("t1_pre_col", sif.col, 1);
      reset = 1'b0;
      #1;
      check("t1_busy0", busy, 0);
      check("t1_req0", {sif.do_rasterize, sif.do_shade, sif.fb_we, frame_done}, 0);
      check("t1_pos0", {sif.row, sif.col, vox_rd_addr}, 0);
      check("t1_vox0", {sif.voxel_x, sif.voxel_y, sif.voxel_z, sif.voxel_id}, 0);
      check("t1_fb0", {sif.fb_addr, sif.fb_data}, 0);
      repeat (3) @(negedge clock);
      #1;
      check("t1_nowrite", wr_addr_q.size(), 1);
      check("t1_nodone", fd_cnt, 0);
      reset = 1'b1;
      clear_mon();

      // count=2 full frame after reset
      start_frame(2);
      wait_done("t2", 2000);
      check_writes("t2");
      check_rises("t2", 2);
      check("t2_idle", {busy, frame_done}, 0);
      clear_mon();

      // count=3 frame with a start pulse (count=5) while busy
      start_frame(3);
      repeat (7) @(negedge clock);
      #1;
      start = 1'b1;
      voxel_count = (AW+1)'(5);
      @(negedge clock);
      #1;
      start = 1'b0;
      voxel_count = '0;
      wait_done("t3", 2000);
      check_writes("t3");
      check_rises("t3", 3);
      clear_mon();

      // count=0: shading only
      start_frame(0);
      wait_done("t4", 2000);
      check_writes("t4");
      check("t4_nrise", rise_x_q.size(), 0);
      check("t4_nshade", shade_rise, ROWS * COLS);
      clear_mon();

      // Slow rasterizer: done after 20 request cycles
      rast_delay = 20;
      start_frame(1);
      wait_done("t6", 4000);
      check_writes("t6");
      check_rises("t6", 1);
      check("t6_run", max_run, 21);
      rast_delay = 3;

      check("overlap", overlap, 0);
      check("unstable", unstable, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
